// File: rtl/sub_seq_pkg.sv
// Shared types and constants for the byte-serial subtract sequencer.
package sub_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_seq_ctrl_if.sv
// Request/response stream bundle for sub_seq_ctrl.
interface sub_seq_ctrl_if
  import sub_seq_pkg::*;
#(
  parameter int NBYTES = 4
);

  localparam int W = BYTE_W * NBYTES;

  logic         istream_val;
  logic         istream_rdy;
  logic [W-1:0] istream_msg_a;
  logic [W-1:0] istream_msg_b;
  logic         ostream_val;
  logic         ostream_rdy;
  logic [W-1:0] ostream_msg;
  logic         ostream_borrow;
  logic         busy;

  modport slave (
    input  istream_val, istream_msg_a, istream_msg_b, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg, ostream_borrow, busy
  );

  modport master (
    output istream_val, istream_msg_a, istream_msg_b, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg, ostream_borrow, busy
  );

endinterface

// File: rtl/sub_seq_ctrl_slice.sv
// One-byte subtract-with-borrow slice, purely combinational.
module sub8_borrow_slice
  import sub_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              bin,
  output logic [BYTE_W-1:0] diff,
  output logic              bout
);

  // A 9-bit subtraction: the wrapped MSB is the outgoing borrow.
  logic [BYTE_W:0] full_s;

  assign full_s       = {1'b0, a} - {1'b0, b} - {{BYTE_W{1'b0}}, bin};
  assign {bout, diff} = full_s;

endmodule

// File: rtl/sub_seq_ctrl.sv
// Byte-serial N-byte unsigned subtractor, LSB first, with val/rdy streams.
module sub_seq_ctrl
  import sub_seq_pkg::*;
#(
  parameter int NBYTES = 4
)(
  input logic           clk,
  input logic           reset,
  sub_seq_ctrl_if.slave io
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t              state_r;
  state_t              state_s;
  logic [IDX_W-1:0]    idx_r;
  logic [W-1:0]        opa_r;
  logic [W-1:0]        opb_r;
  logic [W-1:0]        result_r;
  logic                borrow_r;
  logic [BYTE_W-1:0]   diff_s;
  logic                bout_s;
  logic                accept_s;
  logic                last_s;

  assign accept_s = io.istream_val && (state_r == IDLE);
  assign last_s   = (idx_r == LAST_IDX);

  sub8_borrow_slice u_slice (
    .a    (opa_r[BYTE_W*int'(idx_r) +: BYTE_W]),
    .b    (opb_r[BYTE_W*int'(idx_r) +: BYTE_W]),
    .bin  (borrow_r),
    .diff (diff_s),
    .bout (bout_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: accept in IDLE, walk bytes in CALC, wait for rdy in DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = CALC;
        else          state_s = IDLE;
      end
      CALC: begin
        if (last_s) state_s = DONE;
        else        state_s = CALC;
      end
      DONE: begin
        if (io.ostream_rdy) state_s = IDLE;
        else                state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand latch on accept, one result byte and borrow per CALC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_r    <= '0;
      opa_r    <= '0;
      opb_r    <= '0;
      result_r <= '0;
      borrow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            opa_r    <= io.istream_msg_a;
            opb_r    <= io.istream_msg_b;
            result_r <= '0;
            borrow_r <= 1'b0;
            idx_r    <= '0;
          end
        end
        CALC: begin
          result_r[BYTE_W*int'(idx_r) +: BYTE_W] <= diff_s;
          borrow_r <= bout_s;
          if (!last_s) idx_r <= idx_r + IDX_W'(1);
        end
        DONE: begin
          // Hold the response until it is taken.
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  // Moore output decodes of registered state.
  assign io.istream_rdy    = (state_r == IDLE);
  assign io.ostream_val    = (state_r == DONE);
  assign io.busy           = (state_r == CALC) || (state_r == DONE);
  assign io.ostream_msg    = result_r;
  assign io.ostream_borrow = borrow_r;

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Self-checking bench for sub_seq_ctrl (NBYTES=4) against an arithmetic model.
module tb_sub_seq_ctrl;

  localparam int NB = 4;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  sub_seq_ctrl_if #(.NBYTES(NB)) bus ();

  sub_seq_ctrl #(.NBYTES(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction; starts and ends at a negedge with the DUT idle.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                         input int stall, input bit noise);
    logic [31:0] exp_msg;
    logic        exp_bor;
    exp_msg = a - b;
    exp_bor = (a < b);
    check("idle_rdy", {63'd0, bus.istream_rdy}, 64'd1);
    bus.istream_val   = 1'b1;
    bus.istream_msg_a = a;
    bus.istream_msg_b = b;
    bus.ostream_rdy   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.istream_val = noise;
    if (noise) begin
      bus.istream_msg_a = 32'hFFFF_FFFF;
      bus.istream_msg_b = 32'hFFFF_FFFF;
    end
    for (int i = 0; i < NB; i++) begin
      check("calc_val_low", {63'd0, bus.ostream_val}, 64'd0);
      check("calc_busy", {63'd0, bus.busy}, 64'd1);
      @(negedge clk);
    end
    check("done_val", {63'd0, bus.ostream_val}, 64'd1);
    check("done_msg", {32'd0, bus.ostream_msg}, {32'd0, exp_msg});
    check("done_borrow", {63'd0, bus.ostream_borrow}, {63'd0, exp_bor});
    for (int s = 0; s < stall; s++) begin
      bus.istream_val = noise;
      @(negedge clk);
      check("stall_val", {63'd0, bus.ostream_val}, 64'd1);
      check("stall_msg", {32'd0, bus.ostream_msg}, {32'd0, exp_msg});
      check("stall_rdy_low", {63'd0, bus.istream_rdy}, 64'd0);
    end
    bus.istream_val = 1'b0;
    bus.ostream_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ostream_rdy = 1'b0;
    check("post_val", {63'd0, bus.ostream_val}, 64'd0);
    check("post_busy", {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    int seen;
    logic [31:0] ra;
    logic [31:0] rb;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.istream_val   = 1'b0;
    bus.istream_msg_a = 32'd0;
    bus.istream_msg_b = 32'd0;
    bus.ostream_rdy   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdy", {63'd0, bus.istream_rdy}, 64'd1);
    check("rst_val", {63'd0, bus.ostream_val}, 64'd0);
    check("rst_msg", {32'd0, bus.ostream_msg}, 64'd0);
    check("rst_borrow", {63'd0, bus.ostream_borrow}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_txn(32'h0000_0005, 32'h0000_0003, 0, 1'b0);
    run_txn(32'h0000_0100, 32'h0000_0001, 0, 1'b0);
    run_txn(32'h0000_0000, 32'h0000_0001, 1, 1'b0);
    run_txn(32'h1234_5678, 32'h1111_1111, 5, 1'b1);
    run_txn(32'h0000_0010, 32'h0000_0001, 2, 1'b1);

    // Asynchronous reset after two CALC edges.
    bus.istream_val   = 1'b1;
    bus.istream_msg_a = 32'hFFFF_FFFF;
    bus.istream_msg_b = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    bus.istream_val = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_val", {63'd0, bus.ostream_val}, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_rdy", {63'd0, bus.istream_rdy}, 64'd1);
    check("abort_msg", {32'd0, bus.ostream_msg}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    bus.ostream_rdy = 1'b1;
    repeat (NB + 4) begin
      @(negedge clk);
      if (bus.ostream_val) seen++;
    end
    bus.ostream_rdy = 1'b0;
    check("abort_no_resp", 64'(seen), 64'd0);
    run_txn(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1'b0);

    // Randomized back-to-back traffic with random stalls.
    for (int t = 0; t < 1000; t++) begin
      ra = $urandom;
      rb = $urandom;
      if (t % 17 == 0) rb = ra;
      if (t % 23 == 0) ra = 32'd0;
      if (t % 29 == 0) rb = 32'hFFFF_FFFF;
      run_txn(ra, rb, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
              1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sub_seq_ctrl.md
# sub_seq_ctrl

Multi-cycle sequencer that performs an unsigned N-byte subtraction by time-multiplexing a single 8-bit subtract-with-borrow slice, one byte per cycle, LSB first. It sits between a latency-insensitive request stream and a response stream using val/rdy handshakes. It is the area-optimised alternative to a full-width combinational subtractor in the arithmetic subsystem.

## Interface

- NBYTES, default 4: operand width in bytes (legal 2..8); full width W = 8*NBYTES.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- istream_val  input  1  request valid.
- istream_rdy  output  1  request ready; high only in IDLE.
- istream_msg_a  input  W  minuend.
- istream_msg_b  input  W  subtrahend.
- ostream_val  output  1  response valid; high only in DONE.
- ostream_rdy  input  1  response ready.
- ostream_msg  output  W  difference a − b mod 2^W.
- ostream_borrow  output  1  final borrow; 1 iff a < b (unsigned).
- busy  output  1  high in CALC or DONE.

## Operation

- States: IDLE, CALC, DONE.
- IDLE: istream_rdy=1. On istream_val && istream_rdy, latch a and b, clear the result register, borrow:=0, idx:=0, and go to CALC. Otherwise stay.
- CALC: the slice computes {bout, diff} = a[idx] − b[idx] − borrow as a 9-bit subtraction. bout = MSB, which equals 1 iff a[idx] < b[idx] + borrow.
  - Each edge: result[idx] := diff, borrow := bout, idx := idx+1.
  - When idx == NBYTES−1: go to DONE instead of incrementing idx.
  - istream_val is ignored while in CALC.
- DONE: ostream_val=1. ostream_msg = result and ostream_borrow = borrow, both held stable. On ostream_rdy go to IDLE. Otherwise hold all outputs unchanged.
- Arithmetic is unsigned, modulo 2^W. No overflow flag; signed interpretation is left to the consumer.
- Inputs istream_msg_a/b are only sampled at the accept edge. Changes afterward have no effect.
- Reset (asynchronous, any state, including mid-CALC): state=IDLE, idx=0, result=0, borrow=0, latched operands=0. The in-flight operation is dropped and no response is produced.
- Output values during and immediately after reset: istream_rdy=1 (IDLE), ostream_val=0, ostream_msg=0, ostream_borrow=0, busy=0. The environment must hold istream_val=0 while reset is asserted.

## Timing

- Accept at edge E0. The CALC cycles follow it; byte k is written at edge E(k+1).
- DONE is entered at edge E_NBYTES. ostream_val rises in the cycle after E_NBYTES.
- Latency: exactly NBYTES cycles from the accept edge to ostream_val high.
- Response handshake completes on the first edge with ostream_val && ostream_rdy. istream_rdy is high in the following cycle.
- No accept in the same cycle as a response handshake. Minimum initiation interval is NBYTES+2 cycles.
- All outputs are registered-state decodes (Moore). There are no combinational paths from any input to any output.

## Structure

- Package sub_seq_pkg holds:
  - a typedef enum for the states {IDLE, CALC, DONE};
  - localparam BYTE_W = 8.
- Sub-module sub8_borrow_slice is purely combinational:
  - inputs a[7:0], b[7:0], bin;
  - outputs diff[7:0], bout.
- The top level holds the FSM, the idx counter ($clog2(NBYTES) bits), the operand registers, the result register and the borrow flop.
- Byte selection uses idx-indexed part-selects. There is no shifting of operand registers.

## Test plan

All scenarios use NBYTES=4.

- a=0x00000005, b=0x00000003 -> ostream_msg=0x00000002, borrow=0; ostream_val rises exactly 4 cycles after the accept edge.
- Borrow ripple: a=0x00000100, b=0x00000001 -> 0x000000FF, borrow=0. Then a=0x00000000, b=0x00000001 -> 0xFFFFFFFF, borrow=1.
- Backpressure: a=0x12345678, b=0x11111111, ostream_rdy low for 5 DONE cycles -> msg stays 0x01234567 and ostream_val stays 1 throughout; istream_rdy=0 and istream_val pulses are ignored; IDLE follows on the cycle after rdy rises.
- Reset asserted asynchronously after 2 CALC cycles of a=0xFFFFFFFF, b=0x00000001:
  - immediately: ostream_val=0, busy=0, istream_rdy=1;
  - no response ever appears for the aborted operation;
  - the next request a=0xDEADBEEF, b=0xDEADBEEF -> 0x00000000, borrow=0.
- Operand change after accept: drive a=0x00000010, b=0x00000001, then change the inputs to 0xFFFFFFFF during CALC -> result is still 0x0000000F.
- 1000 random back-to-back transactions with random ostream_rdy stalls -> every response matches (a−b) mod 2^32 with borrow=(a<b), in order, with no drops or duplicates.
